sipo_deserializer: RTL and testbench
====================================

// Module: sipo_deserializer
// PURPOSE
//   Serial-in/parallel-out receiver; the collecting end of the team's shift-register links.
//   - Gathers WIDTH serial bits, qualified by sin_en, into a shift register.
//   - Transfers each completed word to an output holding register with a valid/ready handshake.
//   - Flags words lost because the consumer has not drained the previous one.
// PARAMETERS
//   WIDTH      4   word length in bits; legal range WIDTH >= 2
//   MSB_FIRST  1   1: first received bit lands in pout[WIDTH-1]; 0: first bit lands in pout[0]
// PORTS
//   clk         in   1                  clock; all state updates on rising edge
//   rst         in   1                  asynchronous, active-high reset
//   sin         in   1                  serial data bit
//   sin_en      in   1                  sin is sampled on this edge when 1
//   clr         in   1                  synchronous frame restart; overrides sin_en
//   pout        out  WIDTH              last completed word (holding register)
//   pout_valid  out  1                  pout holds an unconsumed word
//   pout_ready  in   1                  consumer accepts pout this edge when pout_valid=1
//   overrun     out  1                  sticky: a completed word was discarded
//   bit_cnt     out  $clog2(WIDTH)      bits collected in current word, 0..WIDTH-1
// BEHAVIOUR
//   - Reset (async, rst=1): shift reg=0, bit_cnt=0, pout=0, pout_valid=0, overrun=0.
//     Outputs hold these values while rst is high. Reset mid-word discards all partial data.
//   - Shift when sin_en=1 and clr=0:
//     - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], sin}.
//     - MSB_FIRST=0: sreg <= {sin, sreg[WIDTH-1:1]}.
//   - bit_cnt increments on each shift.
//     - Completion edge: sin_en=1, clr=0, bit_cnt==WIDTH-1.
//     - On completion, bit_cnt wraps to 0 and sreg is left holding the completed word.
//   - sin_en=0: sreg and bit_cnt hold. Gaps of any length between bits are legal.
//   - Output register is a 2-state FSM:
//     - EMPTY (pout_valid=0):
//       - completion -> load pout with the completed word; go FULL.
//     - FULL (pout_valid=1):
//       - pout_ready=1, no completion -> pout_valid=0; go EMPTY. pout keeps its old value.
//       - pout_ready=1 and completion on the same edge -> load new word; stay FULL. No overrun.
//       - pout_ready=0 and completion -> new word discarded; overrun<=1; pout unchanged; stay FULL.
//   - Latency: pout/pout_valid update on the same edge that samples the WIDTH-th bit.
//     They are visible immediately after that edge.
//   - pout is stable whenever pout_valid=1 and pout_ready=0.
//   - clr=1 (synchronous):
//     - Sets sreg=0, bit_cnt=0, overrun=0; the current sin is not sampled.
//     - pout, pout_valid and the handshake are unaffected; a pout_ready on that edge is still honoured.
//   - overrun clears only on clr or rst. Further overruns keep it at 1.
//   - pout_ready while pout_valid=0 has no effect.
// TESTING
//   1. WIDTH=4, MSB_FIRST=1, ready=0; sin 1,0,1,1 on 4 consecutive enabled edges
//      -> after 4th edge pout=4'b1011, pout_valid=1, bit_cnt=0, overrun=0.
//   2. Continue from 1, ready=0; send 0,1,1,0
//      -> overrun=1, pout stays 4'b1011, pout_valid=1.
//      Then ready=1 for one edge -> pout_valid=0.
//   3. pout_valid=1; ready=1 on the same edge as the 4th bit of 0,1,1,0
//      -> pout=4'b0110, pout_valid=1, overrun=0.
//   4. sin_en toggling 1,0,0,1,... across word 1,1,0,0 with 3-cycle gaps
//      -> bit_cnt advances only on enabled edges; pout=4'b1100 on the 4th enabled bit.
//   5. After 2 bits: clr=1 -> bit_cnt=0, overrun=0, pout unchanged.
//      After 2 bits: rst=1 mid-cycle -> all outputs 0 immediately, without a clock edge.
//   6. MSB_FIRST=0; sin 1,1,0,1 -> pout=4'b1011.
//      WIDTH=8 variant: 8 bits of 8'hA5 -> pout=8'hA5 after 8 enabled edges.

Source files
------------

// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//   Serial-in/parallel-out receiver. Collects WIDTH serial bits, each qualified
//   by sin_en, into a shift register. A completed word is handed to an output
//   holding register that uses a valid/ready handshake. If the consumer has
//   not drained the previous word, the new word is dropped and the sticky
//   overrun flag is set.
//
// Parameters
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1: first received bit ends up in pout[WIDTH-1]
//              0: first received bit ends up in pout[0]
//
// Ports
//   clk         clock; all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   sin         serial data bit
//   sin_en      sample sin on this edge
//   clr         synchronous frame restart; overrides sin_en
//   pout        last completed word (holding register)
//   pout_valid  pout holds an unconsumed word
//   pout_ready  consumer takes pout on this edge when pout_valid=1
//   overrun     sticky: a completed word was discarded
//   bit_cnt     bits collected in the current word, 0..WIDTH-1
// -----------------------------------------------------------------------------
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sin,
  input  logic                     sin_en,
  input  logic                     clr,
  output logic [WIDTH-1:0]         pout,
  output logic                     pout_valid,
  input  logic                     pout_ready,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q,  sreg_d;
  logic [WIDTH-1:0] pout_q,  pout_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             ovr_q,   ovr_d;

  logic [WIDTH-1:0] shifted;
  logic             complete;

  // The shift register after taking sin; on a completion edge this is the
  // finished word, so it can be loaded into pout on that same edge.
  assign shifted  = MSB_FIRST ? {sreg_q[WIDTH-2:0], sin}
                              : {sin, sreg_q[WIDTH-1:1]};
  assign complete = sin_en && !clr && (cnt_q == CW'(WIDTH - 1));

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (clr) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (sin_en) begin
      sreg_d = shifted;
      cnt_d  = complete ? '0 : cnt_q + CW'(1);
    end
  end

  // Output holding register. clr only touches overrun here; the handshake
  // carries on normally on a clr edge (complete is already 0 then).
  always_comb begin
    state_d = state_q;
    pout_d  = pout_q;
    ovr_d   = clr ? 1'b0 : ovr_q;
    unique case (state_q)
      EMPTY: begin
        if (complete) begin
          pout_d  = shifted;
          state_d = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          if (pout_ready) pout_d = shifted;  // drain and refill together
          else            ovr_d  = 1'b1;     // consumer too slow: drop word
        end else if (pout_ready) begin
          state_d = EMPTY;                   // pout keeps the stale value
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      sreg_q  <= '0;
      pout_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      pout_q  <= pout_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pout       = pout_q;
  assign pout_valid = (state_q == FULL);
  assign overrun    = ovr_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deserializer
//   Directed bench for sipo_deserializer. Three instances share clk/rst:
//   dut_a (WIDTH=4, MSB first) carries the main sequence, dut_b (WIDTH=4,
//   LSB first) and dut_c (WIDTH=8, MSB first) cover the parameter variants.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_sipo_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // dut_a
  logic       sin_a = 1'b0, en_a = 1'b0, clr_a = 1'b0, rdy_a = 1'b0;
  logic [3:0] pout_a;
  logic       val_a, ovr_a;
  logic [1:0] cnt_a;

  // dut_b
  logic       sin_b = 1'b0, en_b = 1'b0, clr_b = 1'b0, rdy_b = 1'b0;
  logic [3:0] pout_b;
  logic       val_b, ovr_b;
  logic [1:0] cnt_b;

  // dut_c
  logic       sin_c = 1'b0, en_c = 1'b0, clr_c = 1'b0, rdy_c = 1'b0;
  logic [7:0] pout_c;
  logic       val_c, ovr_c;
  logic [2:0] cnt_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .sin(sin_a), .sin_en(en_a), .clr(clr_a),
    .pout(pout_a), .pout_valid(val_a), .pout_ready(rdy_a),
    .overrun(ovr_a), .bit_cnt(cnt_a)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .sin(sin_b), .sin_en(en_b), .clr(clr_b),
    .pout(pout_b), .pout_valid(val_b), .pout_ready(rdy_b),
    .overrun(ovr_b), .bit_cnt(cnt_b)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst(rst), .sin(sin_c), .sin_en(en_c), .clr(clr_c),
    .pout(pout_c), .pout_valid(val_c), .pout_ready(rdy_c),
    .overrun(ovr_c), .bit_cnt(cnt_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge for dut_a with the given serial bit / enable.
  task automatic tick_a(input logic s, input logic e);
    sin_a = s;
    en_a  = e;
    @(posedge clk);
    #1;
  endtask

  // Four enabled edges for dut_a; bits[3] is sent first.
  task automatic send4_a(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) tick_a(bits[i], 1'b1);
    en_a = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_pout",  32'(pout_a), 32'h0);
    check("rst_valid", 32'(val_a),  32'h0);
    check("rst_ovr",   32'(ovr_a),  32'h0);
    check("rst_cnt",   32'(cnt_a),  32'h0);
    rst = 1'b0;

    // ---------------- 1: first word 1011, ready=0 ----------------
    rdy_a = 1'b0;
    tick_a(1'b1, 1'b1);
    tick_a(1'b0, 1'b1);
    check("t1_cnt2",   32'(cnt_a), 32'd2);
    check("t1_noval",  32'(val_a), 32'h0);
    tick_a(1'b1, 1'b1);
    tick_a(1'b1, 1'b1);
    en_a = 1'b0;
    check("t1_pout",   32'(pout_a), 32'hB);
    check("t1_valid",  32'(val_a),  32'h1);
    check("t1_cnt",    32'(cnt_a),  32'h0);
    check("t1_ovr",    32'(ovr_a),  32'h0);

    // ---------------- 2: overrun, then drain ----------------
    send4_a(4'b0110);
    check("t2_ovr",    32'(ovr_a),  32'h1);
    check("t2_pout",   32'(pout_a), 32'hB);
    check("t2_valid",  32'(val_a),  32'h1);
    send4_a(4'b0011);
    check("t2_ovr_sticky", 32'(ovr_a), 32'h1);
    rdy_a = 1'b1;
    tick_a(1'b0, 1'b0);
    rdy_a = 1'b0;
    check("t2_drain_valid", 32'(val_a),  32'h0);
    check("t2_drain_pout",  32'(pout_a), 32'hB);
    check("t2_drain_ovr",   32'(ovr_a),  32'h1);
    // ready while empty has no effect
    rdy_a = 1'b1;
    tick_a(1'b0, 1'b0);
    rdy_a = 1'b0;
    check("t2_idle_rdy_valid", 32'(val_a), 32'h0);

    // clr clears overrun, leaves pout alone
    clr_a = 1'b1;
    tick_a(1'b1, 1'b1);
    clr_a = 1'b0;
    check("clr_ovr",  32'(ovr_a),  32'h0);
    check("clr_pout", 32'(pout_a), 32'hB);
    check("clr_cnt",  32'(cnt_a),  32'h0);

    // ---------------- 3: drain and refill on the same edge ----------------
    send4_a(4'b1111);
    check("t3_pre_pout",  32'(pout_a), 32'hF);
    check("t3_pre_valid", 32'(val_a),  32'h1);
    tick_a(1'b0, 1'b1);
    tick_a(1'b1, 1'b1);
    tick_a(1'b1, 1'b1);
    rdy_a = 1'b1;
    tick_a(1'b0, 1'b1);
    rdy_a = 1'b0;
    en_a  = 1'b0;
    check("t3_pout",  32'(pout_a), 32'h6);
    check("t3_valid", 32'(val_a),  32'h1);
    check("t3_ovr",   32'(ovr_a),  32'h0);
    rdy_a = 1'b1;
    tick_a(1'b0, 1'b0);
    rdy_a = 1'b0;
    check("t3_drain_valid", 32'(val_a), 32'h0);

    // ---------------- 4: gaps between enabled bits ----------------
    tick_a(1'b1, 1'b1);
    tick_a(1'b0, 1'b0);
    tick_a(1'b1, 1'b0);
    tick_a(1'b0, 1'b0);
    check("t4_cnt1", 32'(cnt_a), 32'd1);
    tick_a(1'b1, 1'b1);
    tick_a(1'b0, 1'b0);
    tick_a(1'b0, 1'b0);
    tick_a(1'b1, 1'b0);
    check("t4_cnt2", 32'(cnt_a), 32'd2);
    tick_a(1'b0, 1'b1);
    tick_a(1'b1, 1'b0);
    tick_a(1'b1, 1'b0);
    tick_a(1'b1, 1'b0);
    check("t4_cnt3",   32'(cnt_a), 32'd3);
    check("t4_noval",  32'(val_a), 32'h0);
    tick_a(1'b0, 1'b1);
    en_a = 1'b0;
    check("t4_pout",  32'(pout_a), 32'hC);
    check("t4_valid", 32'(val_a),  32'h1);
    check("t4_cnt0",  32'(cnt_a),  32'h0);

    // ---------------- 5: clr mid-word, then async reset mid-word ----------------
    tick_a(1'b1, 1'b1);
    tick_a(1'b0, 1'b1);
    check("t5_cnt2", 32'(cnt_a), 32'd2);
    clr_a = 1'b1;
    rdy_a = 1'b1;        // handshake still honoured on a clr edge
    tick_a(1'b1, 1'b1);
    clr_a = 1'b0;
    rdy_a = 1'b0;
    check("t5_clr_cnt",   32'(cnt_a),  32'h0);
    check("t5_clr_ovr",   32'(ovr_a),  32'h0);
    check("t5_clr_pout",  32'(pout_a), 32'hC);
    check("t5_clr_valid", 32'(val_a),  32'h0);
    // refill so pout_valid=1 going into reset
    send4_a(4'b1001);
    check("t5_refill", 32'(pout_a), 32'h9);
    send4_a(4'b0101);    // overrun so every output is nonzero
    check("t5_ovr_set", 32'(ovr_a), 32'h1);
    tick_a(1'b1, 1'b1);
    tick_a(1'b1, 1'b1);
    en_a = 1'b0;
    #2 rst = 1'b1;       // mid-cycle, no clock edge
    #1;
    check("t5_rst_pout",  32'(pout_a), 32'h0);
    check("t5_rst_valid", 32'(val_a),  32'h0);
    check("t5_rst_ovr",   32'(ovr_a),  32'h0);
    check("t5_rst_cnt",   32'(cnt_a),  32'h0);
    // outputs hold while rst stays high, even with enabled bits
    tick_a(1'b1, 1'b1);
    check("t5_rst_hold_cnt", 32'(cnt_a), 32'h0);
    rst = 1'b0;
    send4_a(4'b0110);    // partial bits from before reset must be gone
    check("t5_post_pout",  32'(pout_a), 32'h6);
    check("t5_post_valid", 32'(val_a),  32'h1);

    // ---------------- 6: LSB-first and WIDTH=8 ----------------
    begin
      logic [3:0] seq_b;
      logic [7:0] seq_c;
      seq_b = 4'b1101;   // sent left to right: 1,1,0,1
      for (int i = 3; i >= 0; i--) begin
        sin_b = seq_b[i];
        en_b  = 1'b1;
        @(posedge clk);
        #1;
      end
      en_b = 1'b0;
      check("t6_lsb_pout",  32'(pout_b), 32'hB);
      check("t6_lsb_valid", 32'(val_b),  32'h1);

      seq_c = 8'hA5;
      for (int i = 7; i >= 1; i--) begin
        sin_c = seq_c[i];
        en_c  = 1'b1;
        @(posedge clk);
        #1;
      end
      check("t6_w8_cnt7",  32'(cnt_c), 32'd7);
      check("t6_w8_noval", 32'(val_c), 32'h0);
      sin_c = seq_c[0];
      @(posedge clk);
      #1;
      en_c = 1'b0;
      check("t6_w8_pout",  32'(pout_c), 32'hA5);
      check("t6_w8_valid", 32'(val_c),  32'h1);
      check("t6_w8_cnt0",  32'(cnt_c),  32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
